// File: rtl/tape_pkg.sv
// rtl/tape_pkg.sv - shared types, defaults and saturating helpers for the tape-in conditioner
package tape_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      ACTIVE = 2'd2
   } tape_state_t;

   localparam int ADC_W_DEF     = 12;
   localparam int AVG_SHIFT_DEF = 6;
   localparam int HYST_DEF      = 64;

   // Threshold math is done in 32 bits and clipped to the caller's range.
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] max_v);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s > {1'b0, max_v}) ? max_v : s[31:0];
   endfunction

   function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
      return (a > b) ? (a - b) : 32'd0;
   endfunction

endpackage

// File: rtl/tape_in_conditioner_if.sv
// rtl/tape_in_conditioner_if.sv - sample stream and status bundle for the tape-in conditioner
// TAPE_PULSE_STATS_EN adds the last_period status field.
interface tape_in_conditioner_if #(
   parameter int ADC_W = 12
);
   logic             enable;
   logic             adc_valid;
   logic [ADC_W-1:0] adc_sample;
   logic             tape_bit;
   logic             tape_edge;
   logic             active;
   logic [ADC_W-1:0] mean_level;
`ifdef TAPE_PULSE_STATS_EN
   logic [15:0]      last_period;

   modport master (
      output enable, adc_valid, adc_sample,
      input  tape_bit, tape_edge, active, mean_level, last_period
   );
   modport slave (
      input  enable, adc_valid, adc_sample,
      output tape_bit, tape_edge, active, mean_level, last_period
   );
`else
   modport master (
      output enable, adc_valid, adc_sample,
      input  tape_bit, tape_edge, active, mean_level
   );
   modport slave (
      input  enable, adc_valid, adc_sample,
      output tape_bit, tape_edge, active, mean_level
   );
`endif
endinterface

// File: rtl/tape_glitch_filter.sv
// rtl/tape_glitch_filter.sv - debounces the level candidate into tape_bit and tape_edge
module tape_glitch_filter #(
   parameter int MIN_PULSE = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic enable_i,
   input  logic valid_i,
   input  logic cand_i,
   output logic tape_bit_o,
   output logic tape_edge_o,
   output logic change_o
);
   localparam int CNT_W = $clog2(MIN_PULSE + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bit_q, bit_d;
   logic             edge_q, edge_d;

   // Disabling drops the level silently: no edge pulse for a forced 1->0.
   always_comb begin
      cnt_d  = cnt_q;
      bit_d  = bit_q;
      edge_d = 1'b0;
      if (!enable_i) begin
         cnt_d = '0;
         bit_d = 1'b0;
      end else if (valid_i) begin
         if (cand_i != bit_q) begin
            if (cnt_q == CNT_W'(MIN_PULSE - 1)) begin
               bit_d  = cand_i;
               cnt_d  = '0;
               edge_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else begin
            cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         bit_q  <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         bit_q  <= bit_d;
         edge_q <= edge_d;
      end
   end

   assign tape_bit_o  = bit_q;
   assign tape_edge_o = edge_q;
   assign change_o    = edge_d;

endmodule

// File: rtl/tape_in_conditioner.sv
// rtl/tape_in_conditioner.sv - ADC to tape bit: DC-tracking mean, hysteresis, glitch filter, activity
// TAPE_PULSE_STATS_EN adds a last_period edge-to-edge sample counter.
module tape_in_conditioner
   import tape_pkg::*;
#(
   parameter int ADC_W       = ADC_W_DEF,
   parameter int AVG_SHIFT   = AVG_SHIFT_DEF,
   parameter int HYST        = HYST_DEF,
   parameter int MIN_PULSE   = 2,
   parameter int ACT_EDGES   = 8,
   parameter int ACT_TIMEOUT = 16384
) (
   input logic                  clk_sys,
   input logic                  reset_n,
   tape_in_conditioner_if.slave bus
);
   localparam int ACC_W  = ADC_W + AVG_SHIFT;
   localparam int GAP_W  = $clog2(ACT_TIMEOUT + 1);
   localparam int ECNT_W = $clog2(ACT_EDGES + 1);
   localparam logic [ADC_W-1:0] MID     = {1'b1, {(ADC_W-1){1'b0}}};
   localparam logic [ACC_W-1:0] ACC_RST = {MID, {AVG_SHIFT{1'b0}}};

   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ADC_W-1:0]  mean, hi, lo;
   logic              cand_q, cand_d;
   logic              change;
   logic              tape_bit, tape_edge;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              timeout;
   logic [ECNT_W-1:0] ecnt_q, ecnt_d, ecnt_inc;
   tape_state_t       state_q, state_d;

   assign mean = acc_q[ACC_W-1:AVG_SHIFT];
   assign hi   = ADC_W'(sat_add(32'(mean), 32'(HYST), 32'((1 << ADC_W) - 1)));
   assign lo   = ADC_W'(sat_sub(32'(mean), 32'(HYST)));

   // The mean keeps tracking even while conditioning is disabled.
   always_comb begin
      acc_d = acc_q;
      if (bus.adc_valid) begin
         acc_d = acc_q - {{AVG_SHIFT{1'b0}}, mean} + {{AVG_SHIFT{1'b0}}, bus.adc_sample};
      end
   end

   always_comb begin
      cand_d = cand_q;
      if (!bus.enable) begin
         cand_d = 1'b0;
      end else if (bus.adc_valid) begin
         if (bus.adc_sample > hi) begin
            cand_d = 1'b1;
         end else if (bus.adc_sample < lo) begin
            cand_d = 1'b0;
         end
      end
   end

   tape_glitch_filter #(
      .MIN_PULSE(MIN_PULSE)
   ) u_filter (
      .clk_i      (clk_sys),
      .rst_ni     (reset_n),
      .enable_i   (bus.enable),
      .valid_i    (bus.adc_valid),
      .cand_i     (cand_d),
      .tape_bit_o (tape_bit),
      .tape_edge_o(tape_edge),
      .change_o   (change)
   );

   // An edge in the same sample as the timeout wins because it clears the gap first.
   always_comb begin
      gap_d = gap_q;
      if (!bus.enable) begin
         gap_d = '0;
      end else if (bus.adc_valid) begin
         if (change) begin
            gap_d = '0;
         end else if (gap_q != GAP_W'(ACT_TIMEOUT)) begin
            gap_d = gap_q + GAP_W'(1);
         end
      end
   end

   assign timeout  = bus.adc_valid && (gap_d == GAP_W'(ACT_TIMEOUT));
   assign ecnt_inc = ecnt_q + ECNT_W'(1);

   always_comb begin
      state_d = state_q;
      ecnt_d  = ecnt_q;
      if (!bus.enable) begin
         state_d = IDLE;
         ecnt_d  = '0;
      end else if (bus.adc_valid) begin
         case (state_q)
            IDLE: begin
               if (change) begin
                  ecnt_d  = ECNT_W'(1);
                  state_d = ARMED;
                  if (ACT_EDGES <= 1) begin
                     state_d = ACTIVE;
                  end
               end
            end
            ARMED: begin
               if (change) begin
                  ecnt_d = ecnt_inc;
                  if (ecnt_inc == ECNT_W'(ACT_EDGES)) begin
                     state_d = ACTIVE;
                  end
               end else if (timeout) begin
                  state_d = IDLE;
                  ecnt_d  = '0;
               end
            end
            ACTIVE: begin
               if (timeout) begin
                  state_d = IDLE;
                  ecnt_d  = '0;
               end
            end
            default: begin
               state_d = IDLE;
               ecnt_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         acc_q   <= ACC_RST;
         cand_q  <= 1'b0;
         gap_q   <= '0;
         ecnt_q  <= '0;
         state_q <= IDLE;
      end else begin
         acc_q   <= acc_d;
         cand_q  <= cand_d;
         gap_q   <= gap_d;
         ecnt_q  <= ecnt_d;
         state_q <= state_d;
      end
   end

`ifdef TAPE_PULSE_STATS_EN
   logic [15:0] per_cnt_q;
   logic [15:0] last_q;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         per_cnt_q <= '0;
         last_q    <= '0;
      end else if (bus.adc_valid) begin
         if (change) begin
            last_q    <= (per_cnt_q == 16'hFFFF) ? 16'hFFFF : per_cnt_q + 16'd1;
            per_cnt_q <= '0;
         end else if (per_cnt_q != 16'hFFFF) begin
            per_cnt_q <= per_cnt_q + 16'd1;
         end
      end
   end

   assign bus.last_period = last_q;
`endif

   assign bus.tape_bit   = tape_bit;
   assign bus.tape_edge  = tape_edge;
   assign bus.active     = (state_q == ACTIVE);
   assign bus.mean_level = mean;

endmodule
